// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero de-stuffing, LSB-first byte assembly, frame status.
// Flag/abort detect 2 clocks after the last pattern bit; a byte is presented 10 clocks after its 8th wire bit.
module rx_deframer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_NewByte,
    output logic [7:0] Rx_Data,
    output logic       Rx_StartFCS,
    output logic       Rx_StopFCS,
    output logic       Rx_EoF,
    output logic       Rx_AbortSignal,
    output logic       Rx_FrameError,
    output logic [7:0] Rx_FrameSize,
    output logic       Rx_Overflow
);

    typedef enum logic {HUNT = 1'b0, FRAME = 1'b1} state_t;

    state_t      r_state, w_next;
    logic        r_rx;
    logic [7:0]  r_win;
    logic        r_flag, r_abort;
    logic        r_dbit, r_dvld;
    logic [2:0]  r_skip, r_ones, r_nbits;
    logic [6:0]  r_sh;
    logic        r_any;
    logic        r_nb, r_start, r_stop, r_asig, r_eof, r_ferr, r_ovf;
    logic        r_endp, r_errp;
    logic [7:0]  r_data, r_size;
    logic        w_is_flag, w_is_abort;
    logic        w_open, w_close, w_abend;

    // Window bit 7 is the newest wire bit, bit 0 the oldest (next to be delivered).
    assign w_is_flag  = (r_win == 8'h7E);
    assign w_is_abort = (r_win == 8'hFE);

    always_comb begin
        w_next  = r_state;
        w_open  = 1'b0;
        w_close = 1'b0;
        w_abend = 1'b0;
        if (r_state == HUNT) begin
            if (r_flag) begin
                w_open = 1'b1;
                w_next = FRAME;
            end
        end else begin
            if (r_flag && r_any) begin
                w_close = 1'b1;
                w_next  = HUNT;
            end else if (r_abort) begin
                w_abend = 1'b1;
                w_next  = HUNT;
            end
        end
        if (!RxEN) begin
            w_next  = HUNT;
            w_open  = 1'b0;
            w_close = 1'b0;
            w_abend = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) r_state <= HUNT;
        else      r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_rx    <= 1'b1;
            r_win   <= 8'hFF;
            r_flag  <= 1'b0;
            r_abort <= 1'b0;
            r_dbit  <= 1'b0;
            r_dvld  <= 1'b0;
            r_skip  <= 3'd0;
            r_ones  <= 3'd0;
            r_nbits <= 3'd0;
            r_sh    <= 7'd0;
            r_any   <= 1'b0;
            r_nb    <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_asig  <= 1'b0;
            r_eof   <= 1'b0;
            r_ferr  <= 1'b0;
            r_endp  <= 1'b0;
            r_errp  <= 1'b0;
            r_ovf   <= 1'b0;
            r_data  <= 8'h00;
            r_size  <= 8'h00;
        end else if (!RxEN) begin
            r_rx    <= 1'b1;
            r_win   <= 8'hFF;
            r_flag  <= 1'b0;
            r_abort <= 1'b0;
            r_dvld  <= 1'b0;
            r_skip  <= 3'd0;
            r_nb    <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_asig  <= 1'b0;
            r_eof   <= 1'b0;
            r_ferr  <= 1'b0;
            r_endp  <= 1'b0;
            r_errp  <= 1'b0;
        end else begin
            r_rx    <= Rx;
            r_win   <= {r_rx, r_win[7:1]};
            r_flag  <= w_is_flag;
            r_abort <= w_is_abort;
            // Flag bits (8 shifts from detection) and the abort's leading 0 never reach byte assembly.
            r_dbit  <= r_win[0];
            r_dvld  <= !w_is_flag && !w_is_abort && (r_skip == 3'd0);
            if (w_is_flag)          r_skip <= 3'd7;
            else if (r_skip != 3'd0) r_skip <= r_skip - 3'd1;

            r_start <= w_open;
            r_stop  <= w_close;
            r_asig  <= w_abend;
            r_endp  <= w_close || w_abend;
            r_errp  <= w_close && (r_nbits != 3'd0);
            r_eof   <= r_endp;
            r_ferr  <= r_errp;
            r_nb    <= 1'b0;

            if (w_open) begin
                r_ones  <= 3'd0;
                r_nbits <= 3'd0;
                r_any   <= 1'b0;
                r_size  <= 8'h00;
                r_ovf   <= 1'b0;
            end else begin
                if (r_nb) begin
                    if (r_size == 8'd128) r_ovf  <= 1'b1;
                    if (r_size != 8'd255) r_size <= r_size + 8'd1;
                end
                if (r_state == FRAME && r_dvld) begin
                    r_any <= 1'b1;
                    if (!r_dbit && r_ones == 3'd5) begin
                        r_ones <= 3'd0;
                    end else begin
                        if (!r_dbit)              r_ones <= 3'd0;
                        else if (r_ones != 3'd7) r_ones <= r_ones + 3'd1;
                        r_sh <= {r_dbit, r_sh[6:1]};
                        if (r_nbits == 3'd7) begin
                            r_data  <= {r_dbit, r_sh};
                            r_nb    <= 1'b1;
                            r_nbits <= 3'd0;
                        end else begin
                            r_nbits <= r_nbits + 3'd1;
                        end
                    end
                end
            end
        end
    end

    assign Rx_FlagDetect  = r_flag;
    assign Rx_AbortDetect = r_abort;
    assign Rx_ValidFrame  = (r_state == FRAME);
    assign Rx_NewByte     = r_nb;
    assign Rx_Data        = r_data;
    assign Rx_StartFCS    = r_start;
    assign Rx_StopFCS     = r_stop;
    assign Rx_EoF         = r_eof;
    assign Rx_AbortSignal = r_asig;
    assign Rx_FrameError  = r_ferr;
    assign Rx_FrameSize   = r_size;
    assign Rx_Overflow    = r_ovf;

endmodule
